// File: rtl/wrap_counter_adj_if.sv
// Control/status bundle for one wrap_counter_adj field.
// The master drives the controls and the slave (the counter) returns value/carry_out.
interface wrap_counter_adj_if #(
   parameter int WIDTH = 12
);
   logic             en_1;
   logic             carry_in;
   logic             adjust;
   logic             up;
   logic             down;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] max_in;
   logic [WIDTH-1:0] value;
   logic             carry_out;

   modport master (
      output en_1, carry_in, adjust, up, down, load, load_val, max_in,
      input  value, carry_out
   );

   modport slave (
      input  en_1, carry_in, adjust, up, down, load, load_val, max_in,
      output value, carry_out
   );
endinterface

// File: rtl/wrap_counter_adj.sv
// Bounded wrap-around counter for calendar/clock fields.
// It counts on chained carries and steps on debounced up/down buttons with hold-to-repeat.
module wrap_counter_adj #(
   parameter int WIDTH      = 12,
   parameter int VAL_MIN    = 2001,
   parameter int VAL_MAX    = 3000,
   parameter int RST_VAL    = 2001,
   parameter int DYN_MAX    = 0,
   parameter int RPT_DELAY  = 500,
   parameter int RPT_PERIOD = 100
) (
   input  logic              clk,
   input  logic              rst,
   wrap_counter_adj_if.slave bus
);
   localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(VAL_MIN);
   localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(VAL_MAX);
   localparam logic [WIDTH-1:0] RST_W   = WIDTH'(RST_VAL);
   localparam int               RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
   localparam int               TW      = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
   localparam logic [TW-1:0]    DELAY_LAST  = TW'(RPT_DELAY - 1);
   localparam logic [TW-1:0]    PERIOD_LAST = TW'(RPT_PERIOD - 1);

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} btn_state_t;

   btn_state_t       state_reg;
   logic [TW-1:0]    timer_reg;
   logic             dir_up_reg;
   logic [WIDTH-1:0] value_reg;
   logic             carry_reg;

   logic [1:0]       btn_raw;
   logic [1:0]       btn_s;
   logic [1:0]       btn_rise;
   logic             press_up;
   logic             press_dn;
   logic             cap_held;
   logic             adj_step;
   logic             adj_up;
   logic             count_step;
   logic [WIDTH-1:0] max_clamped;
   logic [WIDTH-1:0] eff_max;
   logic [WIDTH-1:0] load_clamped;

   // Bit 0 carries the up button, bit 1 the down button.
   assign btn_raw = {bus.down, bus.up};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_sync
         logic [1:0] sync_reg;
         logic       prev_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sync_reg <= 2'b00;
               prev_reg <= 1'b0;
            end else begin
               sync_reg <= {sync_reg[0], btn_raw[gi]};
               prev_reg <= sync_reg[1];
            end
         end

         assign btn_s[gi]    = sync_reg[1];
         assign btn_rise[gi] = sync_reg[1] & ~prev_reg;
      end
   endgenerate

   assign max_clamped  = (bus.max_in < MIN_W) ? MIN_W :
                         (bus.max_in > MAX_W) ? MAX_W : bus.max_in;
   assign eff_max      = (DYN_MAX != 0) ? max_clamped : MAX_W;
   assign load_clamped = (bus.load_val < MIN_W)   ? MIN_W :
                         (bus.load_val > eff_max) ? eff_max : bus.load_val;

   // A press only counts when the other button is idle; a held captured button with the
   // other one pressed too is treated as a release.
   assign press_up   = btn_rise[0] & ~btn_s[1];
   assign press_dn   = btn_rise[1] & ~btn_s[0];
   assign cap_held   = dir_up_reg ? (btn_s[0] & ~btn_s[1]) : (btn_s[1] & ~btn_s[0]);
   assign count_step = ~bus.adjust & bus.en_1 & bus.carry_in;

   always_comb begin
      adj_step = 1'b0;
      adj_up   = dir_up_reg;
      if (bus.adjust) begin
         case (state_reg)
            IDLE: begin
               if (press_up | press_dn) begin
                  adj_step = 1'b1;
                  adj_up   = press_up;
               end
            end
            DELAY:   adj_step = cap_held && (timer_reg == DELAY_LAST);
            REPEAT:  adj_step = cap_held && (timer_reg == PERIOD_LAST);
            default: adj_step = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         timer_reg  <= '0;
         dir_up_reg <= 1'b1;
      end else if (!bus.adjust) begin
         state_reg <= IDLE;
         timer_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (press_up | press_dn) begin
                  state_reg  <= DELAY;
                  timer_reg  <= '0;
                  dir_up_reg <= press_up;
               end
            end
            DELAY: begin
               if (!cap_held) begin
                  state_reg <= IDLE;
               end else if (timer_reg == DELAY_LAST) begin
                  state_reg <= REPEAT;
                  timer_reg <= '0;
               end else begin
                  timer_reg <= timer_reg + TW'(1);
               end
            end
            REPEAT: begin
               if (!cap_held) begin
                  state_reg <= IDLE;
               end else if (timer_reg == PERIOD_LAST) begin
                  timer_reg <= '0;
               end else begin
                  timer_reg <= timer_reg + TW'(1);
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // An out-of-range value (max_in just dropped) is pulled back before any counting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_reg <= RST_W;
         carry_reg <= 1'b0;
      end else begin
         carry_reg <= 1'b0;
         if (bus.load) begin
            value_reg <= load_clamped;
         end else if (value_reg > eff_max) begin
            value_reg <= eff_max;
         end else if (count_step) begin
            if (value_reg == eff_max) begin
               value_reg <= MIN_W;
               carry_reg <= 1'b1;
            end else begin
               value_reg <= value_reg + WIDTH'(1);
            end
         end else if (adj_step) begin
            if (adj_up) begin
               value_reg <= (value_reg == eff_max) ? MIN_W : value_reg + WIDTH'(1);
            end else begin
               value_reg <= (value_reg == MIN_W) ? eff_max : value_reg - WIDTH'(1);
            end
         end
      end
   end

   assign bus.value     = value_reg;
   assign bus.carry_out = carry_reg;
endmodule

// File: tb/tb_wrap_counter_adj.sv
// Bench for wrap_counter_adj: directed scenarios plus randomized traffic checked every cycle
// against an arithmetic model of the field (hold-length based repeat, modular wrap).
module tb_wrap_counter_adj;
   localparam int W     = 12;
   localparam int VMIN  = 2001;
   localparam int VMAX  = 3000;
   localparam int RSTV  = 2001;
   localparam int D     = 5;
   localparam int P     = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   wrap_counter_adj_if #(.WIDTH(W)) bus ();

   wrap_counter_adj #(
      .WIDTH(W), .VAL_MIN(VMIN), .VAL_MAX(VMAX), .RST_VAL(RSTV),
      .DYN_MAX(1), .RPT_DELAY(D), .RPT_PERIOD(P)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int m_val;
   bit m_carry;
   bit uh[3];
   bit dh[3];
   int hdir;   // 0 none, 1 up held, 2 down held
   int hlen;   // edges since the press that started the hold

   always @(posedge clk or posedge rst) begin
      int  emax, n, lv, adir;
      bit  us, usp, ds, dsp, astep, held;
      if (rst) begin
         m_val   = RSTV;
         m_carry = 0;
         for (int i = 0; i < 3; i++) begin uh[i] = 0; dh[i] = 0; end
         hdir = 0;
         hlen = 0;
      end else begin
         emax = int'(bus.max_in);
         if (emax < VMIN) emax = VMIN;
         if (emax > VMAX) emax = VMAX;
         n  = emax - VMIN + 1;
         // synchronised level is the raw level two edges back
         us = uh[1]; usp = uh[2]; ds = dh[1]; dsp = dh[2];
         astep = 0;
         adir  = 0;
         if (!bus.adjust) begin
            hdir = 0;
         end else if (hdir == 0) begin
            if (us && !usp && !ds) begin astep = 1; adir = 1; hdir = 1; hlen = 0; end
            else if (ds && !dsp && !us) begin astep = 1; adir = 2; hdir = 2; hlen = 0; end
         end else begin
            held = (hdir == 1) ? (us && !ds) : (ds && !us);
            if (!held) begin
               hdir = 0;
            end else begin
               hlen++;
               if (hlen == D || (hlen > D && (hlen - D) % P == 0)) begin
                  astep = 1;
                  adir  = hdir;
               end
            end
         end
         uh[2] = uh[1]; uh[1] = uh[0]; uh[0] = bus.up;
         dh[2] = dh[1]; dh[1] = dh[0]; dh[0] = bus.down;

         m_carry = 0;
         if (bus.load) begin
            lv = int'(bus.load_val);
            if (lv < VMIN) lv = VMIN;
            if (lv > emax) lv = emax;
            m_val = lv;
         end else if (m_val > emax) begin
            m_val = emax;
         end else if (!bus.adjust && bus.en_1 && bus.carry_in) begin
            if (m_val == emax) m_carry = 1;
            m_val = VMIN + (m_val - VMIN + 1) % n;
         end else if (astep) begin
            if (adir == 1) m_val = VMIN + (m_val - VMIN + 1) % n;
            else           m_val = VMIN + (m_val - VMIN - 1 + n) % n;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (!rst) begin
         n_checks++;
         if (bus.value !== W'(m_val)) begin
            n_fail++;
            $display("FAIL value t=%0t: dut=%0d model=%0d", $time, bus.value, m_val);
         end
         n_checks++;
         if (bus.carry_out !== m_carry) begin
            n_fail++;
            $display("FAIL carry_out t=%0t: dut=%0b model=%0b", $time, bus.carry_out, m_carry);
         end
      end
   end

   // Hand-computed expectations pin both the DUT and the model.
   task automatic check_lit(input string name, input int exp_val, input bit exp_carry);
      n_checks++;
      if (bus.value !== W'(exp_val) || bus.carry_out !== exp_carry) begin
         n_fail++;
         $display("FAIL %s: dut value=%0d carry=%0b, expected value=%0d carry=%0b",
                  name, bus.value, bus.carry_out, exp_val, exp_carry);
      end else begin
         $display("check %s: value=%0d carry=%0b", name, bus.value, bus.carry_out);
      end
      n_checks++;
      if (m_val != exp_val || m_carry != exp_carry) begin
         n_fail++;
         $display("FAIL %s_model: model value=%0d carry=%0b, expected value=%0d carry=%0b",
                  name, m_val, m_carry, exp_val, exp_carry);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_load(input int v);
      bus.load = 1'b1; bus.load_val = W'(v);
      tick(1);
      bus.load = 1'b0;
   endtask

   int btn_left;
   int btn_pat;

   initial begin
      bus.en_1 = 0; bus.carry_in = 0; bus.adjust = 0; bus.up = 0; bus.down = 0;
      bus.load = 0; bus.load_val = '0; bus.max_in = W'(VMAX);
      tick(2);
      rst = 1'b0;
      tick(1);
      check_lit("reset_state", 2001, 0);

      // count wrap at the static max
      do_load(3000);
      check_lit("load_3000", 3000, 0);
      bus.en_1 = 1; bus.carry_in = 1;
      tick(1);
      bus.en_1 = 0; bus.carry_in = 0;
      check_lit("count_wrap", 2001, 1);
      tick(1);
      check_lit("carry_one_cycle", 2001, 0);

      // adjust: down at min wraps to max after 3-clk latency, up wraps back
      bus.adjust = 1; bus.down = 1;
      tick(2);
      check_lit("press_latency_2clk", 2001, 0);
      tick(1);
      check_lit("adj_down_wrap", 3000, 0);
      bus.down = 0;
      tick(4);
      check_lit("adj_down_single", 3000, 0);
      bus.up = 1;
      tick(3);
      check_lit("adj_up_wrap", 2001, 0);
      bus.up = 0;
      tick(4);

      // auto-repeat: raw held 10 edges -> steps at press, +5, +7, +9
      bus.up = 1;
      tick(7);
      check_lit("repeat_press", 2002, 0);
      tick(1);
      check_lit("repeat_first", 2003, 0);
      tick(2);
      check_lit("repeat_second", 2004, 0);
      bus.up = 0;
      tick(2);
      check_lit("repeat_third", 2005, 0);
      tick(4);
      check_lit("repeat_released", 2005, 0);

      // asynchronous reset while repeating
      bus.up = 1;
      tick(9);
      #2 rst = 1'b1; bus.up = 0;
      #1 check_lit("rst_async", 2001, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      tick(8);
      check_lit("idle_after_rst", 2001, 0);

      // runtime max: value above new bound is pulled down, then wraps at it
      bus.adjust = 0;
      do_load(3000);
      bus.max_in = W'(2500);
      tick(1);
      check_lit("dyn_clamp", 2500, 0);
      bus.en_1 = 1; bus.carry_in = 1;
      tick(1);
      bus.en_1 = 0; bus.carry_in = 0;
      check_lit("dyn_wrap", 2001, 1);
      bus.max_in = W'(100);
      do_load(2600);
      check_lit("dyn_low_max_load", 2001, 0);
      bus.en_1 = 1; bus.carry_in = 1;
      tick(1);
      bus.en_1 = 0; bus.carry_in = 0;
      check_lit("dyn_low_max_wrap", 2001, 1);
      bus.max_in = W'(VMAX);

      // conflicts
      do_load(2500);
      bus.load = 1; bus.load_val = W'(2100); bus.en_1 = 1; bus.carry_in = 1;
      tick(1);
      bus.load = 0;
      check_lit("load_beats_count", 2100, 0);
      bus.adjust = 1;
      tick(3);
      check_lit("count_blocked_adjust", 2100, 0);
      bus.en_1 = 0; bus.carry_in = 0;
      bus.up = 1; bus.down = 1;
      tick(8);
      bus.up = 0; bus.down = 0;
      tick(4);
      check_lit("both_buttons", 2100, 0);
      bus.adjust = 0;

      // randomized traffic
      btn_left = 0;
      btn_pat  = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         bus.en_1     = $urandom_range(0, 1);
         bus.carry_in = ($urandom_range(0, 3) != 0);
         bus.load     = ($urandom_range(0, 24) == 0);
         bus.load_val = W'($urandom_range(1950, 3100));
         if ($urandom_range(0, 59) == 0) bus.adjust = ~bus.adjust;
         if ($urandom_range(0, 99) == 0)
            bus.max_in = ($urandom_range(0, 1) != 0) ? W'(VMAX) : W'($urandom_range(1950, 3050));
         if (btn_left == 0) begin
            btn_pat  = $urandom_range(0, 7);
            btn_left = $urandom_range(1, 25);
         end
         btn_left--;
         bus.up   = (btn_pat == 3 || btn_pat == 4 || btn_pat == 6);
         bus.down = (btn_pat == 5 || btn_pat == 6 || btn_pat == 7);
         if ($urandom_range(0, 699) == 0) begin
            #2 rst = 1'b1;
            @(negedge clk);
            #2 rst = 1'b0;
         end
      end
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
